// File: rtl/condiciona_botoes.sv
// rtl/condiciona_botoes.sv - button conditioner: synchronizer, per-key debounce, press pulses
// Channel index 0 is the enter key, index 1 is the reuse key.
module condiciona_botoes #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_enter,
    input  logic btn_reuso,
    output logic enter,
    output logic reuso,
    output logic enter_nivel,
    output logic reuso_nivel
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [1:0]      RELEASED = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    logic [1:0]    r_sync0;
    logic [1:0]    r_sync1;
    logic [1:0]    r_lvl;
    logic [CW-1:0] r_cnt [2];
    logic          r_enter;
    logic          r_reuso;

    logic [1:0]    w_samp;
    logic [1:0]    w_lvl_next;
    logic [CW-1:0] w_cnt_next [2];
    logic [1:0]    w_rise;

    assign w_samp = (ACTIVE_LOW != 0) ? ~r_sync1 : r_sync1;

    // A level change needs DEBOUNCE_CYCLES consecutive differing samples;
    // any agreeing sample restarts the count.
    always_comb begin
        w_lvl_next = r_lvl;
        for (int i = 0; i < 2; i++) begin
            w_cnt_next[i] = '0;
            if (w_samp[i] != r_lvl[i]) begin
                if (r_cnt[i] + CW'(1) == CNT_MAX) begin
                    w_lvl_next[i] = w_samp[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_rise = w_lvl_next & ~r_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= RELEASED;
            r_sync1 <= RELEASED;
            r_lvl   <= 2'b00;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
            r_enter <= 1'b0;
            r_reuso <= 1'b0;
        end else begin
            r_sync0 <= {btn_reuso, btn_enter};
            r_sync1 <= r_sync0;
            r_lvl   <= w_lvl_next;
            r_cnt[0] <= w_cnt_next[0];
            r_cnt[1] <= w_cnt_next[1];
            r_enter <= w_rise[0];
            // enter wins a simultaneous press; the reuse pulse is dropped, not deferred
            r_reuso <= w_rise[1] & ~w_rise[0];
        end
    end

    assign enter       = r_enter;
    assign reuso       = r_reuso;
    assign enter_nivel = r_lvl[0];
    assign reuso_nivel = r_lvl[1];

endmodule

// File: tb/tb_condiciona_botoes.sv
// tb/tb_condiciona_botoes.sv - directed self-checking bench for condiciona_botoes
module tb_condiciona_botoes;

    logic clk = 1'b0;
    logic rst;
    logic btn_enter;
    logic btn_reuso;
    logic enter;
    logic reuso;
    logic enter_nivel;
    logic reuso_nivel;

    int n_tests = 0;
    int n_fail  = 0;
    int n_enter_pulses = 0;
    int n_reuso_pulses = 0;
    int n_both_high    = 0;
    int base_e;
    int base_r;

    condiciona_botoes #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_enter  (btn_enter),
        .btn_reuso  (btn_reuso),
        .enter      (enter),
        .reuso      (reuso),
        .enter_nivel(enter_nivel),
        .reuso_nivel(reuso_nivel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (enter) n_enter_pulses++;
        if (reuso) n_reuso_pulses++;
        if (enter && reuso) n_both_high++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_enter = 1'b1;
        btn_reuso = 1'b1;
        edges(3);
        check("reset_enter", enter, 0);
        check("reset_reuso", reuso, 0);
        check("reset_enter_nivel", enter_nivel, 0);
        check("reset_reuso_nivel", reuso_nivel, 0);
        rst = 1'b0;
        edges(8);
        check("idle_enter_nivel", enter_nivel, 0);

        // clean press: level and pulse together on the 6th edge
        base_e = n_enter_pulses;
        btn_enter = 1'b0;
        edges(5);
        check("press_nivel_e5", enter_nivel, 0);
        check("press_pulse_e5", enter, 0);
        edges(1);
        check("press_nivel_e6", enter_nivel, 1);
        check("press_pulse_e6", enter, 1);
        check("press_reuso_e6", reuso, 0);
        edges(1);
        check("press_pulse_e7", enter, 0);
        check("press_nivel_e7", enter_nivel, 1);
        btn_enter = 1'b1;
        edges(5);
        check("release_nivel_e5", enter_nivel, 1);
        edges(1);
        check("release_nivel_e6", enter_nivel, 0);
        edges(4);
        check("press_pulse_count", n_enter_pulses - base_e, 1);

        // bounce: low 3, high 1, low held
        base_e = n_enter_pulses;
        btn_enter = 1'b0;
        edges(3);
        btn_enter = 1'b1;
        edges(1);
        btn_enter = 1'b0;
        edges(5);
        check("bounce_nivel_e5", enter_nivel, 0);
        check("bounce_no_early_pulse", n_enter_pulses - base_e, 0);
        edges(1);
        check("bounce_nivel_e6", enter_nivel, 1);
        check("bounce_pulse_e6", enter, 1);
        btn_enter = 1'b1;
        edges(10);
        check("bounce_pulse_count", n_enter_pulses - base_e, 1);
        check("bounce_released", enter_nivel, 0);

        // hold reuse 50 cycles, then release
        base_r = n_reuso_pulses;
        btn_reuso = 1'b0;
        edges(6);
        check("hold_reuso_pulse_e6", reuso, 1);
        check("hold_reuso_nivel_e6", reuso_nivel, 1);
        edges(44);
        check("hold_pulse_count", n_reuso_pulses - base_r, 1);
        check("hold_nivel", reuso_nivel, 1);
        btn_reuso = 1'b1;
        edges(5);
        check("hold_release_e5", reuso_nivel, 1);
        edges(1);
        check("hold_release_e6", reuso_nivel, 0);
        edges(4);
        check("hold_release_no_pulse", n_reuso_pulses - base_r, 1);

        // simultaneous press
        base_e = n_enter_pulses;
        base_r = n_reuso_pulses;
        btn_enter = 1'b0;
        btn_reuso = 1'b0;
        edges(6);
        check("simul_enter_e6", enter, 1);
        check("simul_reuso_e6", reuso, 0);
        check("simul_enter_nivel", enter_nivel, 1);
        check("simul_reuso_nivel", reuso_nivel, 1);
        edges(10);
        check("simul_enter_count", n_enter_pulses - base_e, 1);
        check("simul_reuso_count", n_reuso_pulses - base_r, 0);
        btn_enter = 1'b1;
        btn_reuso = 1'b1;
        edges(10);
        check("simul_released", enter_nivel + reuso_nivel, 0);

        // reset while enter count = 3, key held through it
        base_e = n_enter_pulses;
        btn_enter = 1'b0;
        edges(5);
        check("midrst_nivel_before", enter_nivel, 0);
        rst = 1'b1;
        edges(1);
        check("midrst_outputs", {enter, reuso, enter_nivel, reuso_nivel}, 0);
        rst = 1'b0;
        edges(5);
        check("midrst_nivel_e5", enter_nivel, 0);
        edges(1);
        check("midrst_nivel_e6", enter_nivel, 1);
        check("midrst_pulse_e6", enter, 1);
        edges(5);
        check("midrst_pulse_count", n_enter_pulses - base_e, 1);

        check("never_both_high", n_both_high, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
